// File: rtl/controlador_ram_pkg.sv
// Shared types and constants for the RAM burst controller.
//   estado_t     : controller states
//   LAT_LECTURA  : RAM read latency in cycles (address -> data)
//   FIFO_PROF    : depth of the read-side skid FIFO
package controlador_ram_pkg;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    ESCRITURA = 2'd1,
    LECTURA   = 2'd2,
    DRENAJE   = 2'd3
  } estado_t;

  localparam int LAT_LECTURA = 1;
  localparam int FIFO_PROF   = 2;

endpackage

// File: rtl/fifo_salida_ram.sv
// Two-entry skid FIFO holding {ultimo, data} for read bursts.
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   vaciar_i         : synchronous flush (drops every entry)
//   push_i           : write push_ultimo_i/push_data_i into the tail
//   pop_i            : drop the head entry
//   head_data_o      : head data word (zero when empty)
//   head_ultimo_o    : head last-word flag (zero when empty)
//   cuenta_o         : number of stored entries
//   vacio_o          : FIFO empty
module fifo_salida_ram
  import controlador_ram_pkg::*;
#(
  parameter int ANCHO = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             vaciar_i,
  input  logic             push_i,
  input  logic [ANCHO-1:0] push_data_i,
  input  logic             push_ultimo_i,
  input  logic             pop_i,
  output logic [ANCHO-1:0] head_data_o,
  output logic             head_ultimo_o,
  output logic [1:0]       cuenta_o,
  output logic             vacio_o
);

  logic [ANCHO:0] entradas [FIFO_PROF];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     cuenta;
  logic           push_ok;
  logic           pop_ok;

  assign push_ok = push_i && (cuenta != 2'(FIFO_PROF));
  assign pop_ok  = pop_i && (cuenta != 2'd0);

  always_ff @(posedge clk_i) begin
    if (reset_i || vaciar_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cuenta <= 2'd0;
    end else begin
      if (push_ok) begin
        entradas[wr_ptr] <= {push_ultimo_i, push_data_i};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      cuenta <= cuenta + 2'(push_ok) - 2'(pop_ok);
    end
  end

  // Stale storage is hidden so an empty FIFO never shows a spurious last flag.
  assign vacio_o       = (cuenta == 2'd0);
  assign head_data_o   = vacio_o ? '0 : entradas[rd_ptr][ANCHO-1:0];
  assign head_ultimo_o = vacio_o ? 1'b0 : entradas[rd_ptr][ANCHO];
  assign cuenta_o      = cuenta;

endmodule

// File: rtl/controlador_rafaga_ram.sv
// Burst master for the synchronous register-file RAM. Takes one command at a
// time (write/read, base address, length) and either streams incoming words
// into consecutive addresses or streams RAM contents out with backpressure.
// Optional feature: define CONTROLADOR_RAFAGA_ABORTO_EN to add aborto_i,
// which returns any busy state to INACTIVO and drops pending read data.
// Ports:
//   clk_i, reset_i                  : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o       : command handshake
//   cmd_escritura_i, cmd_dir_i,
//   cmd_largo_i                     : command fields (largo 0..2**PROFUNDIDAD)
//   wr_valid_i / wr_ready_o, wr_data_i : write word stream
//   rd_valid_o / rd_ready_i, rd_data_o,
//   rd_ultimo_o                     : read word stream, last-beat marker
//   mem_we_o, mem_addr_o, mem_data_o,
//   mem_data_i                      : RAM port (read data one cycle after address)
//   ocupado_o                       : burst in progress
//   aborto_i (optional)             : abort current burst
//
// state     | meaning
// ----------+------------------------------------------------------------
// INACTIVO  | idle, accepting commands
// ESCRITURA | writing one word per wr handshake
// LECTURA   | issuing reads, throttled by FIFO room
// DRENAJE   | all reads issued, waiting for the last word to be taken
module controlador_rafaga_ram
  import controlador_ram_pkg::*;
#(
  parameter int ANCHO       = 8,
  parameter int PROFUNDIDAD = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
`ifdef CONTROLADOR_RAFAGA_ABORTO_EN
  input  logic                   aborto_i,
`endif
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_escritura_i,
  input  logic [PROFUNDIDAD-1:0] cmd_dir_i,
  input  logic [PROFUNDIDAD:0]   cmd_largo_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [ANCHO-1:0]       wr_data_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [ANCHO-1:0]       rd_data_o,
  output logic                   rd_ultimo_o,
  output logic                   mem_we_o,
  output logic [PROFUNDIDAD-1:0] mem_addr_o,
  output logic [ANCHO-1:0]       mem_data_o,
  input  logic [ANCHO-1:0]       mem_data_i,
  output logic                   ocupado_o
);

  localparam logic [PROFUNDIDAD-1:0] UNO_DIR   = PROFUNDIDAD'(1);
  localparam logic [PROFUNDIDAD:0]   UNO_LARGO = (PROFUNDIDAD + 1)'(1);
  localparam logic [PROFUNDIDAD:0]   CERO_LARGO = '0;

  estado_t                estado_q, estado_d;
  logic [PROFUNDIDAD-1:0] dir_q, dir_d;
  logic [PROFUNDIDAD:0]   restante_q, restante_d;
  logic [LAT_LECTURA-1:0] en_vuelo_q;
  logic [LAT_LECTURA-1:0] ultimo_vuelo_q;
  logic                   emitir;
  logic                   aborto;
  logic                   pop;
  logic [ANCHO-1:0]       head_data;
  logic                   head_ultimo;
  logic [1:0]             cuenta;
  logic                   vacio;
  logic [2:0]             ocupacion;

`ifdef CONTROLADOR_RAFAGA_ABORTO_EN
  assign aborto = aborto_i && (estado_q != INACTIVO);
`else
  assign aborto = 1'b0;
`endif

  assign pop = !vacio && rd_ready_i;

  // Room check counts the word leaving this cycle, so a consumer that keeps
  // rd_ready_i high sees one word per cycle with only two slots.
  assign ocupacion = {1'b0, cuenta} - {2'b00, pop} + 3'($countones(en_vuelo_q));

  always_comb begin
    estado_d    = estado_q;
    dir_d       = dir_q;
    restante_d  = restante_q;
    emitir      = 1'b0;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    mem_we_o    = 1'b0;
    mem_data_o  = '0;

    case (estado_q)
      INACTIVO: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          dir_d      = cmd_dir_i;
          restante_d = cmd_largo_i;
          if (cmd_largo_i != CERO_LARGO) begin
            estado_d = cmd_escritura_i ? ESCRITURA : LECTURA;
          end
        end
      end

      ESCRITURA: begin
        wr_ready_o = 1'b1;
        mem_we_o   = wr_valid_i;
        mem_data_o = wr_data_i;
        if (wr_valid_i) begin
          dir_d      = dir_q + UNO_DIR;
          restante_d = restante_q - UNO_LARGO;
          if (restante_q == UNO_LARGO) begin
            estado_d = INACTIVO;
          end
        end
      end

      LECTURA: begin
        if (ocupacion < 3'(FIFO_PROF)) begin
          emitir     = 1'b1;
          dir_d      = dir_q + UNO_DIR;
          restante_d = restante_q - UNO_LARGO;
          if (restante_q == UNO_LARGO) begin
            estado_d = DRENAJE;
          end
        end
      end

      DRENAJE: begin
        if ((pop && head_ultimo) || (vacio && (en_vuelo_q == '0))) begin
          estado_d = INACTIVO;
        end
      end

      default: estado_d = INACTIVO;
    endcase

    if (aborto) begin
      estado_d = INACTIVO;
      emitir   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      estado_q       <= INACTIVO;
      dir_q          <= '0;
      restante_q     <= '0;
      en_vuelo_q     <= '0;
      ultimo_vuelo_q <= '0;
    end else begin
      estado_q   <= estado_d;
      dir_q      <= dir_d;
      restante_q <= restante_d;
      if (aborto) begin
        en_vuelo_q     <= '0;
        ultimo_vuelo_q <= '0;
      end else begin
        // Delay line matching the RAM read latency; the oldest bit marks
        // the cycle in which mem_data_i carries the issued word.
        en_vuelo_q     <= LAT_LECTURA'({en_vuelo_q, emitir});
        ultimo_vuelo_q <= LAT_LECTURA'({ultimo_vuelo_q, emitir && (restante_q == UNO_LARGO)});
      end
    end
  end

  fifo_salida_ram #(
    .ANCHO (ANCHO)
  ) u_fifo (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .vaciar_i      (aborto),
    .push_i        (en_vuelo_q[LAT_LECTURA-1]),
    .push_data_i   (mem_data_i),
    .push_ultimo_i (ultimo_vuelo_q[LAT_LECTURA-1]),
    .pop_i         (pop),
    .head_data_o   (head_data),
    .head_ultimo_o (head_ultimo),
    .cuenta_o      (cuenta),
    .vacio_o       (vacio)
  );

  assign rd_valid_o  = !vacio;
  assign rd_data_o   = head_data;
  assign rd_ultimo_o = head_ultimo;
  assign mem_addr_o  = dir_q;
  assign ocupado_o   = (estado_q != INACTIVO);

endmodule

// File: tb/tb_controlador_rafaga_ram.sv
module tb_controlador_rafaga_ram;

  localparam int ANCHO = 8;
  localparam int PROF  = 8;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic            aborto_i = 1'b0;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic            cmd_escritura_i = 1'b0;
  logic [PROF-1:0] cmd_dir_i = '0;
  logic [PROF:0]   cmd_largo_i = '0;
  logic            wr_valid_i = 1'b0;
  logic            wr_ready_o;
  logic [ANCHO-1:0] wr_data_i = '0;
  logic            rd_valid_o;
  logic            rd_ready_i = 1'b0;
  logic [ANCHO-1:0] rd_data_o;
  logic            rd_ultimo_o;
  logic            mem_we_o;
  logic [PROF-1:0] mem_addr_o;
  logic [ANCHO-1:0] mem_data_o;
  logic [ANCHO-1:0] mem_data_i = '0;
  logic            ocupado_o;

  logic [ANCHO-1:0] ram     [256];
  logic [ANCHO-1:0] ref_mem [256];
  logic             cargar = 1'b1;

  int checks  = 0;
  int errores = 0;

  always #5 clk_i = ~clk_i;

  // Synchronous RAM model: one-cycle read latency.
  always @(posedge clk_i) begin
    if (cargar) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (mem_we_o) ram[mem_addr_o] <= mem_data_o;
      mem_data_i <= ram[mem_addr_o];
    end
  end

  controlador_rafaga_ram #(.ANCHO(ANCHO), .PROFUNDIDAD(PROF)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
`ifdef CONTROLADOR_RAFAGA_ABORTO_EN
    .aborto_i        (aborto_i),
`endif
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_escritura_i (cmd_escritura_i),
    .cmd_dir_i       (cmd_dir_i),
    .cmd_largo_i     (cmd_largo_i),
    .wr_valid_i      (wr_valid_i),
    .wr_ready_o      (wr_ready_o),
    .wr_data_i       (wr_data_i),
    .rd_valid_o      (rd_valid_o),
    .rd_ready_i      (rd_ready_i),
    .rd_data_o       (rd_data_o),
    .rd_ultimo_o     (rd_ultimo_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_data_i      (mem_data_i),
    .ocupado_o       (ocupado_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errores++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic enviar_cmd(input logic esc, input logic [7:0] dir, input logic [8:0] largo);
    cmd_valid_i     = 1'b1;
    cmd_escritura_i = esc;
    cmd_dir_i       = dir;
    cmd_largo_i     = largo;
    #1 chk("cmd_ready_accept", cmd_ready_o, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic escribir(input logic [7:0] dir, input int largo, input logic [7:0] base);
    logic [7:0] a;
    logic [7:0] d;
    for (int i = 0; i < largo; i++) begin
      a = 8'(dir + 8'(i));
      d = 8'(base + 8'(i));
      wr_valid_i = 1'b1;
      wr_data_i  = d;
      #1;
      chk("wr_ready", wr_ready_o, 1);
      chk("mem_we", mem_we_o, 1);
      chk("mem_addr_wr", mem_addr_o, a);
      chk("mem_data_wr", mem_data_o, d);
      ref_mem[a] = d;
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0;
    #1;
    chk("wr_end_ocupado", ocupado_o, 0);
    chk("wr_end_cmd_ready", cmd_ready_o, 1);
  endtask

  // modo 0: rd_ready held high; modo 1: rd_ready toggles 1,0,1,0...
  task automatic leer(input logic [7:0] dir, input int largo, input int modo,
                      input int parar, output logic [7:0] ultima_dir);
    int beat = 0;
    int ciclo = 0;
    int huecos = 0;
    int oc_max = 0;
    int oc;
    logic [7:0] a;
    ultima_dir = 8'h00;
    while (beat < parar && ciclo < largo * 4 + 20) begin
      rd_ready_i = (modo == 0) ? 1'b1 : ((ciclo % 2) == 0);
      #1;
      oc = int'(dut.u_fifo.cuenta_o) + int'(dut.en_vuelo_q);
      if (oc > oc_max) oc_max = oc;
      if (dut.emitir) ultima_dir = mem_addr_o;
      if (rd_valid_o && rd_ready_i) begin
        a = 8'(dir + 8'(beat));
        chk("rd_data", rd_data_o, ref_mem[a]);
        chk("rd_ultimo", rd_ultimo_o, (beat == largo - 1));
        beat++;
      end else if (modo == 0 && beat > 0) begin
        huecos++;
      end
      @(negedge clk_i);
      ciclo++;
    end
    chk("rd_beats", beat, parar);
    chk("rd_huecos", huecos, 0);
    chk("rd_ocupacion_max", (oc_max <= 2), 1);
    if (parar == largo) begin
      #1;
      chk("rd_end_ocupado", ocupado_o, 0);
      chk("rd_end_cmd_ready", cmd_ready_o, 1);
      chk("rd_end_valid", rd_valid_o, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ult;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

    // Reset state
    @(negedge clk_i);
    cargar = 1'b0;
    @(negedge clk_i);
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_ultimo", rd_ultimo_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_ocupado", ocupado_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // 1: write A0..A3 at 0x10, read back back-to-back
    enviar_cmd(1'b1, 8'h10, 9'd4);
    escribir(8'h10, 4, 8'hA0);
    enviar_cmd(1'b0, 8'h10, 9'd4);
    leer(8'h10, 4, 0, 4, ult);
    chk("t1_ultima_dir", ult, 8'h13);

    // 2: write across the address wrap, read it back
    enviar_cmd(1'b1, 8'hFE, 9'd3);
    escribir(8'hFE, 3, 8'h31);
    enviar_cmd(1'b0, 8'hFE, 9'd3);
    leer(8'hFE, 3, 0, 3, ult);
    chk("t2_ultima_dir", ult, 8'h00);

    // 3: read 8 with toggling backpressure
    enviar_cmd(1'b0, 8'h40, 9'd8);
    leer(8'h40, 8, 1, 8, ult);
    chk("t3_ultima_dir", ult, 8'h47);

    // 4: zero-length command
    rd_ready_i = 1'b1;
    enviar_cmd(1'b1, 8'h50, 9'd0);
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_mem_we", mem_we_o, 0);
      chk("t4_rd_valid", rd_valid_o, 0);
      chk("t4_cmd_ready", cmd_ready_o, 1);
      chk("t4_ocupado", ocupado_o, 0);
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0;

    // 5: full-depth read from 0x80
    enviar_cmd(1'b0, 8'h80, 9'd256);
    leer(8'h80, 256, 0, 256, ult);
    chk("t5_ultima_dir", ult, 8'h7F);

    // Busy controller refuses commands
    enviar_cmd(1'b0, 8'h00, 9'd4);
    cmd_valid_i = 1'b1;
    #1 chk("busy_cmd_ready", cmd_ready_o, 0);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    leer(8'h00, 4, 0, 4, ult);

    // 6: reset in the middle of a read burst
    enviar_cmd(1'b0, 8'h20, 9'd8);
    leer(8'h20, 8, 0, 3, ult);
    reset_i    = 1'b1;
    rd_ready_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("t6_rd_valid", rd_valid_o, 0);
    chk("t6_cmd_ready", cmd_ready_o, 1);
    chk("t6_ocupado", ocupado_o, 0);
    chk("t6_mem_addr", mem_addr_o, 0);
    chk("t6_rd_ultimo", rd_ultimo_o, 0);
    enviar_cmd(1'b1, 8'h30, 9'd2);
    escribir(8'h30, 2, 8'hC0);
    enviar_cmd(1'b0, 8'h30, 9'd2);
    leer(8'h30, 2, 0, 2, ult);

    $display("Simulation finished: %0d checks, %0d errors", checks, errores);
    $finish;
  end

endmodule

// File: doc/controlador_rafaga_ram.md
Name: controlador_rafaga_ram

Overview:
- Burst master that drives the team's synchronous register-file RAM through its write-enable/address/data port.
- Accepts one command at a time (write or read, base address, length) over a valid/ready handshake.
- Write bursts: streams incoming words into consecutive addresses.
- Read bursts: streams RAM contents out over a valid/ready interface with backpressure.
- Sits between the RAM and any producer/consumer logic, e.g. the UART/display front-ends.

Parameters:
- ANCHO, 8, data word width in bits.
- PROFUNDIDAD, 8, address width in bits; the RAM holds 2**PROFUNDIDAD words.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  controller can accept a command.
- cmd_escritura_i  input  1  1 = write burst, 0 = read burst.
- cmd_dir_i  input  PROFUNDIDAD  base address.
- cmd_largo_i  input  PROFUNDIDAD+1  word count, 0..2**PROFUNDIDAD.
- wr_valid_i  input  1  write word present.
- wr_ready_o  output  1  write word accepted.
- wr_data_i  input  ANCHO  write word.
- rd_valid_o  output  1  read word present.
- rd_ready_i  input  1  consumer accepts read word.
- rd_data_o  output  ANCHO  read word.
- rd_ultimo_o  output  1  marks last word of the burst; qualified by rd_valid_o.
- mem_we_o  output  1  RAM write enable.
- mem_addr_o  output  PROFUNDIDAD  RAM address.
- mem_data_o  output  ANCHO  RAM write data.
- mem_data_i  input  ANCHO  RAM read data; valid exactly 1 cycle after the address is presented.
- ocupado_o  output  1  high whenever state != INACTIVO.

Behaviour:
- Reset (synchronous, reset_i=1 at a rising edge):
  - State -> INACTIVO; address and remaining-count registers cleared.
  - Skid FIFO emptied; any in-flight read is discarded.
  - Outputs: cmd_ready_o=1 (INACTIVO); wr_ready_o=0; rd_valid_o=0; rd_ultimo_o=0; mem_we_o=0; mem_addr_o=0; mem_data_o=0; ocupado_o=0.
  - RAM contents are not touched.
- State INACTIVO:
  - cmd_ready_o=1.
  - On cmd_valid_i&&cmd_ready_o: latch dir and largo.
  - largo=0 -> stay INACTIVO (no memory access, no rd beat).
  - Otherwise -> ESCRITURA or LECTURA per cmd_escritura_i.
- State ESCRITURA:
  - wr_ready_o=1.
  - mem_we_o = wr_valid_i (combinational, same cycle); mem_addr_o = current address; mem_data_o = wr_data_i.
  - Each handshake: address+1 (mod 2**PROFUNDIDAD), remaining-1.
  - Final handshake -> INACTIVO next cycle; cmd_ready_o=1 that cycle.
- State LECTURA:
  - mem_we_o=0 always.
  - Issue a read (present address) in a cycle only if FIFO occupancy + in-flight < 2. This sustains 1 word/cycle when rd_ready_i is held high.
  - Each issue: address+1, remaining-1.
  - The data returned on mem_data_i the next cycle is pushed into the FIFO with ultimo = (it was the last issue).
  - After the last issue -> DRENAJE.
- State DRENAJE:
  - No new issues.
  - -> INACTIVO once the FIFO is empty and nothing is in flight, i.e. the cycle after the rd_ultimo_o word is accepted.
- Read output:
  - rd_valid_o = FIFO not empty; rd_data_o/rd_ultimo_o = FIFO head.
  - Pop on rd_valid_o&&rd_ready_i.
  - Data is order-preserving; no loss or duplication under any rd_ready_i pattern.
- Commands offered while ocupado_o=1 are not accepted (cmd_ready_o=0).
- wr_valid_i outside ESCRITURA is ignored.
- Address wraps 2**PROFUNDIDAD-1 -> 0.
- largo = 2**PROFUNDIDAD covers every word once, ending at base-1.

Optional Feature:
- Macro CONTROLADOR_RAFAGA_ABORTO_EN.
- Defined:
  - Adds input aborto_i (1 bit).
  - aborto_i=1 at a rising edge in any busy state -> INACTIVO next cycle.
  - FIFO flushed and in-flight read dropped; writes already performed remain in the RAM.
  - aborto_i has lower priority than reset_i and is ignored in INACTIVO.
- Not defined: the port does not exist; bursts always run to completion.

Decomposition:
- Package controlador_ram_pkg:
  - enum estado_t {INACTIVO, ESCRITURA, LECTURA, DRENAJE}.
  - Constant LAT_LECTURA=1.
  - Constant FIFO_PROF=2.
- Sub-module fifo_salida_ram: 2-entry skid FIFO of {ultimo, data}, with push, pop and count outputs; synchronous reset/flush.

Test Plan:
1. Write dir=0x10, largo=4, data A0..A3, wr_valid_i high -> mem_we_o high 4 consecutive cycles at 0x10..0x13. Then read dir=0x10, largo=4, rd_ready_i=1 -> rd_data_o A0,A1,A2,A3 on consecutive cycles, rd_ultimo_o only with A3.
2. Write dir=0xFE, largo=3 -> writes at 0xFE, 0xFF, 0x00. Read back the same range -> identical values.
3. Read largo=8 with rd_ready_i toggling 1,0,1,0 -> 8 beats in address order, none lost or duplicated, and never more than 2 words buffered plus in flight.
4. Command largo=0 -> accepted in one cycle; no mem_we_o and no rd_valid_o; cmd_ready_o stays 1.
5. Read dir=0x80, largo=256 -> 256 beats; last address issued is 0x7F; rd_ultimo_o on beat 256 only.
6. reset_i pulsed after read beat 3 of 8 -> next cycle rd_valid_o=0, cmd_ready_o=1, ocupado_o=0. A new write command is accepted immediately.
